// File: rtl/int_ctrl.sv
// int_ctrl: prioritised interrupt controller.
//
// Captures rising edges of the peripheral interrupt levels into PEND, gates
// them with MASK and the global enable CTRL.GIE, and runs the CPU handshake
// (request -> ack -> service -> done). Source 0 has the highest priority.
//
// Register map on the I/O data-address space:
//   BASE_ADDR+0  PEND  pending bits, write-1-to-clear
//   BASE_ADDR+1  MASK  per-source enable, read/write
//   BASE_ADDR+2  CTRL  bit0 = GIE, read/write
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   irq_src[N_SRC]     level interrupt sources, synchronous to clk
//   read, write        one-cycle I/O strobes; d_addr / wr_data / rd_data
//   int_req/int_vector request and handler address to the CPU
//   int_ack, int_done  CPU took the request / returned from interrupt
//   active, active_id  interrupt currently in service
//
// Build option: define INT_CTRL_NESTING_EN to let a strictly higher-priority
// source preempt the one in service (the preempted ids are kept on a stack).
module int_ctrl #(
    parameter int          N_SRC     = 4,
    parameter logic [15:0] BASE_ADDR = 16'hFF10,
    parameter logic [15:0] VEC_BASE  = 16'h0010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             read,
    input  logic             write,
    input  logic [15:0]      d_addr,
    input  logic [15:0]      wr_data,
    output logic [15:0]      rd_data,
    output logic             int_req,
    output logic [15:0]      int_vector,
    input  logic             int_ack,
    input  logic             int_done,
    output logic             active,
    output logic [2:0]       active_id
);

    localparam logic [15:0] PEND_ADDR = BASE_ADDR;
    localparam logic [15:0] MASK_ADDR = BASE_ADDR + 16'd1;
    localparam logic [15:0] CTRL_ADDR = BASE_ADDR + 16'd2;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state, state_n;
    logic [N_SRC-1:0] pend, mask, irq_prev;
    logic             gie;
    logic [2:0]       req_id;

    logic [N_SRC-1:0] edge_det, w1c_clr, ack_clr, req_oh;
    logic             cand_vld, req_live;
    logic [2:0]       cand_id;
    logic             grant, take_ack, take_done;
    logic             pend_wr, mask_wr, ctrl_wr;

    // Only the low N_SRC bits of wr_data carry information.
    logic unused_wr_bits;
    assign unused_wr_bits = ^wr_data;

`ifdef INT_CTRL_NESTING_EN
    localparam int DW = $clog2(N_SRC + 1);
    logic [N_SRC-1:0][2:0] id_stack;
    logic [DW-1:0]         depth;
    logic                  preempt;
`endif

    assign edge_det = irq_src & ~irq_prev;
    assign pend_wr  = write && (d_addr == PEND_ADDR);
    assign mask_wr  = write && (d_addr == MASK_ADDR);
    assign ctrl_wr  = write && (d_addr == CTRL_ADDR);
    assign w1c_clr  = pend_wr ? wr_data[N_SRC-1:0] : '0;

    // Lowest pending-and-enabled index wins; scan high to low so the last
    // hit is the lowest index.
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = 3'd0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (pend[k] && mask[k]) begin
                cand_vld = 1'b1;
                cand_id  = 3'(k);
            end
        end
    end

    // One-hot of the frozen request id, used for ack-clear and to check
    // that the request is still justified.
    always_comb begin
        req_oh = '0;
        for (int k = 0; k < N_SRC; k++)
            req_oh[k] = (req_id == 3'(k));
    end

    assign req_live = gie && |(pend & mask & req_oh);
    assign ack_clr  = take_ack ? req_oh : '0;

`ifdef INT_CTRL_NESTING_EN
    assign preempt = gie && cand_vld && (cand_id < active_id);
`endif

    // Next-state logic
    always_comb begin
        state_n   = state;
        grant     = 1'b0;
        take_ack  = 1'b0;
        take_done = 1'b0;
        case (state)
            IDLE: begin
                if (gie && cand_vld) begin
                    grant   = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                // An ack means the CPU already vectored; it is honoured
                // even if the request would otherwise be withdrawn.
                if (int_ack) begin
                    take_ack = 1'b1;
                    state_n  = SERVICE;
                end else if (!req_live) begin
                    // Withdrawn: fall back to whatever was running before.
                    state_n = active ? SERVICE : IDLE;
                end
            end
            SERVICE: begin
                if (int_done) begin
                    take_done = 1'b1;
`ifdef INT_CTRL_NESTING_EN
                    state_n = (depth != '0) ? SERVICE : IDLE;
`else
                    state_n = IDLE;
`endif
                end
`ifdef INT_CTRL_NESTING_EN
                else if (preempt) begin
                    grant   = 1'b1;
                    state_n = REQ;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Datapath / register file
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev   <= '0;
            pend       <= '0;
            mask       <= '0;
            gie        <= 1'b0;
            req_id     <= 3'd0;
            int_req    <= 1'b0;
            int_vector <= VEC_BASE;
            active     <= 1'b0;
            active_id  <= 3'd0;
`ifdef INT_CTRL_NESTING_EN
            id_stack   <= '0;
            depth      <= '0;
`endif
        end else begin
            irq_prev <= irq_src;
            // A new edge wins over any clear in the same cycle.
            pend     <= (pend & ~(w1c_clr | ack_clr)) | edge_det;
            if (mask_wr) mask <= wr_data[N_SRC-1:0];
            if (ctrl_wr) gie  <= wr_data[0];

            int_req <= (state_n == REQ);
            if (grant) begin
                req_id     <= cand_id;
                int_vector <= VEC_BASE + {11'd0, cand_id, 2'b00};
            end

            if (take_ack) begin
                active    <= 1'b1;
                active_id <= req_id;
`ifdef INT_CTRL_NESTING_EN
                // Preempting: save the interrupted id.
                if (active) begin
                    for (int i = N_SRC - 1; i > 0; i--)
                        id_stack[i] <= id_stack[i-1];
                    id_stack[0] <= active_id;
                    depth       <= depth + DW'(1);
                end
`endif
            end

            if (take_done) begin
`ifdef INT_CTRL_NESTING_EN
                if (depth != '0) begin
                    active_id <= id_stack[0];
                    for (int i = 0; i < N_SRC - 1; i++)
                        id_stack[i] <= id_stack[i+1];
                    id_stack[N_SRC-1] <= 3'd0;
                    depth             <= depth - DW'(1);
                end else begin
                    active <= 1'b0;
                end
`else
                active <= 1'b0;
`endif
            end
        end
    end

    // Combinational read port
    always_comb begin
        rd_data = '0;
        if (read) begin
            if (d_addr == PEND_ADDR)      rd_data[N_SRC-1:0] = pend;
            else if (d_addr == MASK_ADDR) rd_data[N_SRC-1:0] = mask;
            else if (d_addr == CTRL_ADDR) rd_data[0]         = gie;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;
    localparam int          N_SRC     = 4;
    localparam logic [15:0] BASE_ADDR = 16'hFF10;
    localparam logic [15:0] VEC_BASE  = 16'h0010;
    localparam logic [15:0] A_PEND    = BASE_ADDR;
    localparam logic [15:0] A_MASK    = BASE_ADDR + 16'd1;
    localparam logic [15:0] A_CTRL    = BASE_ADDR + 16'd2;

    logic             clk = 1'b0;
    logic             rst, read, write, int_ack, int_done;
    logic [N_SRC-1:0] irq_src;
    logic [15:0]      d_addr, wr_data;
    logic [15:0]      rd_data, int_vector;
    logic             int_req, active;
    logic [2:0]       active_id;

    int n_tests = 0;
    int n_fail  = 0;

    int_ctrl #(.N_SRC(N_SRC), .BASE_ADDR(BASE_ADDR), .VEC_BASE(VEC_BASE)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .read(read), .write(write),
        .d_addr(d_addr), .wr_data(wr_data), .rd_data(rd_data),
        .int_req(int_req), .int_vector(int_vector), .int_ack(int_ack),
        .int_done(int_done), .active(active), .active_id(active_id)
    );

    always #5 clk = ~clk;

    // ---------------- reference helpers ----------------
    function automatic logic [15:0] vec_of(input int k);
        logic [15:0] v;
        v = VEC_BASE + 16'(4 * k);
        return v;
    endfunction

    function automatic int lowest(input int set);
        for (int i = 0; i < N_SRC; i++) if (set[i]) return i;
        return -1;
    endfunction

    function automatic int popcnt(input int set);
        int c = 0;
        for (int i = 0; i < N_SRC; i++) if (set[i]) c++;
        return c;
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; read = 0; write = 0; int_ack = 0; int_done = 0;
        irq_src = '0; d_addr = '0; wr_data = '0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic reg_wr(input logic [15:0] a, input logic [15:0] d);
        write = 1'b1; d_addr = a; wr_data = d;
        tick;
        write = 1'b0;
    endtask

    task automatic reg_rd(input logic [15:0] a, output logic [15:0] v);
        read = 1'b1; d_addr = a;
        #1 v = rd_data;
        read = 1'b0;
        #1;
    endtask

    task automatic pulse(input int set);
        irq_src = N_SRC'(set);
        tick;
        irq_src = '0;
    endtask

    task automatic strobe_ack;
        int_ack = 1'b1; tick; int_ack = 1'b0;
    endtask

    task automatic strobe_done;
        int_done = 1'b1; tick; int_done = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int c = 0;
        while (int_req !== 1'b1 && c < 8) begin tick; c++; end
        n_tests++;
        if (int_req !== 1'b1) begin
            n_fail++; $display("FAIL %s: int_req timeout, got %b required 1", name, int_req);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [15:0] v;
        do_reset;
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int_req: got %b required 0", int_req); end
        n_tests++; if (int_vector !== VEC_BASE) begin n_fail++; $display("FAIL reset_vector: got %h required %h", int_vector, VEC_BASE); end
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b required 0", active); end
        n_tests++; if (active_id !== 3'd0) begin n_fail++; $display("FAIL reset_active_id: got %0d required 0", active_id); end
        n_tests++; if (rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h required 0", rd_data); end
        reg_rd(A_PEND, v);
        n_tests++; if (v !== 16'h0) begin n_fail++; $display("FAIL reset_pend: got %h required 0", v); end
        reg_rd(A_MASK, v);
        n_tests++; if (v !== 16'h0) begin n_fail++; $display("FAIL reset_mask: got %h required 0", v); end
        reg_rd(A_CTRL, v);
        n_tests++; if (v !== 16'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h required 0", v); end
    endtask

    task automatic test_basic;
        logic [15:0] v;
        int k;
        for (int it = 0; it < 4; it++) begin
            k = (it == 0) ? 1 : int'($urandom_range(N_SRC - 1));
            do_reset;
            reg_wr(A_CTRL, 16'h0001);
            reg_wr(A_MASK, 16'(1 << k));
            irq_src[k] = 1'b1;
            tick;
            irq_src = '0;
            n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL basic_latency1 src%0d: int_req got %b required 0", k, int_req); end
            tick;
            n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL basic_latency2 src%0d: int_req got %b required 1", k, int_req); end
            n_tests++; if (int_vector !== vec_of(k)) begin n_fail++; $display("FAIL basic_vector src%0d: got %h required %h", k, int_vector, vec_of(k)); end
            strobe_ack;
            n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL basic_ack_req src%0d: got %b required 0", k, int_req); end
            n_tests++; if (active !== 1'b1 || active_id !== 3'(k)) begin n_fail++; $display("FAIL basic_active src%0d: got %b/%0d required 1/%0d", k, active, active_id, k); end
            reg_rd(A_PEND, v);
            n_tests++; if (v !== 16'h0) begin n_fail++; $display("FAIL basic_pend_clr src%0d: got %h required 0", k, v); end
            strobe_done;
            n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL basic_done src%0d: active got %b required 0", k, active); end
        end
    endtask

    task automatic test_priority;
        int set, rem, e;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) set = 4'b1001;
            else do set = int'($urandom_range(1, (1 << N_SRC) - 1)); while (popcnt(set) < 2);
            do_reset;
            reg_wr(A_CTRL, 16'h0001);
            reg_wr(A_MASK, 16'h00FF);
            pulse(set);
            rem = set;
            while (rem != 0) begin
                e = lowest(rem);
                wait_req("prio_req");
                n_tests++; if (int_vector !== vec_of(e)) begin n_fail++; $display("FAIL prio_vector set=%h: got %h required %h", set, int_vector, vec_of(e)); end
                strobe_ack;
                n_tests++; if (active_id !== 3'(e)) begin n_fail++; $display("FAIL prio_active_id set=%h: got %0d required %0d", set, active_id, e); end
                strobe_done;
                rem &= ~(1 << e);
            end
            tick; tick;
            n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL prio_drained set=%h: int_req got %b required 0", set, int_req); end
        end
    endtask

    task automatic test_gie_off;
        logic [15:0] v;
        int k;
        k = int'($urandom_range(N_SRC - 1));
        do_reset;
        reg_wr(A_MASK, 16'h00FF);
        pulse(1 << k);
        tick; tick; tick;
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL gie_off_req: got %b required 0", int_req); end
        reg_rd(A_PEND, v);
        n_tests++; if (v !== 16'(1 << k)) begin n_fail++; $display("FAIL gie_off_pend: got %h required %h", v, 16'(1 << k)); end
        int_ack = 1'b1; tick; int_ack = 1'b0;   // stray ack in IDLE
        reg_rd(A_PEND, v);
        n_tests++; if (v !== 16'(1 << k)) begin n_fail++; $display("FAIL stray_ack_pend: got %h required %h", v, 16'(1 << k)); end
        reg_wr(A_PEND, 16'(1 << k));
        reg_rd(A_PEND, v);
        n_tests++; if (v !== 16'h0) begin n_fail++; $display("FAIL w1c: got %h required 0", v); end
        irq_src[k] = 1'b1;
        reg_wr(A_PEND, 16'(1 << k));             // edge and clear in the same cycle
        irq_src = '0;
        reg_rd(A_PEND, v);
        n_tests++; if (v !== 16'(1 << k)) begin n_fail++; $display("FAIL set_wins: got %h required %h", v, 16'(1 << k)); end
    endtask

    task automatic test_withdraw;
        logic [15:0] v;
        int k;
        for (int variant = 0; variant < 2; variant++) begin
            k = int'($urandom_range(N_SRC - 1));
            do_reset;
            reg_wr(A_CTRL, 16'h0001);
            reg_wr(A_MASK, 16'(1 << k));
            pulse(1 << k);
            wait_req("withdraw_req");
            int_done = 1'b1; tick; int_done = 1'b0; // stray done in REQ
            n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL stray_done: int_req got %b required 1", int_req); end
            if (variant == 0) reg_wr(A_MASK, 16'h0000);
            else              reg_wr(A_CTRL, 16'h0000);
            tick;
            n_tests++; if (int_req !== 1'b0 || active !== 1'b0) begin n_fail++; $display("FAIL withdraw v%0d: req/active got %b/%b required 0/0", variant, int_req, active); end
            reg_rd(A_PEND, v);
            n_tests++; if (v !== 16'(1 << k)) begin n_fail++; $display("FAIL withdraw_pend v%0d: got %h required %h", variant, v, 16'(1 << k)); end
        end
    endtask

    task automatic test_regs;
        logic [15:0] v, d, a;
        do_reset;
        for (int i = 0; i < 6; i++) begin
            d = 16'($urandom);
            reg_wr(A_MASK, d);
            reg_rd(A_MASK, v);
            n_tests++; if (v !== (d & 16'((1 << N_SRC) - 1))) begin n_fail++; $display("FAIL mask_rw: got %h required %h", v, d & 16'((1 << N_SRC) - 1)); end
            d = 16'($urandom);
            reg_wr(A_CTRL, d);
            reg_rd(A_CTRL, v);
            n_tests++; if (v !== {15'd0, d[0]}) begin n_fail++; $display("FAIL ctrl_rw: got %h required %h", v, {15'd0, d[0]}); end
        end
        reg_rd(BASE_ADDR + 16'd3, v);
        n_tests++; if (v !== 16'h0) begin n_fail++; $display("FAIL unmapped_base3: got %h required 0", v); end
        for (int i = 0; i < 4; i++) begin
            do a = 16'($urandom); while (a == A_PEND || a == A_MASK || a == A_CTRL);
            reg_wr(a, 16'hFFFF);
            reg_rd(a, v);
            n_tests++; if (v !== 16'h0) begin n_fail++; $display("FAIL unmapped_rand %h: got %h required 0", a, v); end
        end
        reg_wr(A_MASK, 16'h000F);
        read = 1'b0; d_addr = A_MASK; #1;
        n_tests++; if (rd_data !== 16'h0) begin n_fail++; $display("FAIL no_read_strobe: got %h required 0", rd_data); end
    endtask

    task automatic test_reset_service;
        logic [15:0] v;
        int k;
        k = int'($urandom_range(1, N_SRC - 1));
        do_reset;
        reg_wr(A_CTRL, 16'h0001);
        reg_wr(A_MASK, 16'h00FF);
        pulse(1 << k);
        wait_req("rst_svc_req");
        strobe_ack;
        n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL rst_svc_pre: active got %b required 1", active); end
        rst = 1'b1; tick; rst = 1'b0;
        n_tests++; if (active !== 1'b0 || int_req !== 1'b0 || active_id !== 3'd0) begin n_fail++; $display("FAIL rst_svc: active/req/id got %b/%b/%0d required 0/0/0", active, int_req, active_id); end
        n_tests++; if (int_vector !== VEC_BASE) begin n_fail++; $display("FAIL rst_svc_vector: got %h required %h", int_vector, VEC_BASE); end
        reg_rd(A_MASK, v);
        n_tests++; if (v !== 16'h0) begin n_fail++; $display("FAIL rst_svc_mask: got %h required 0", v); end
    endtask

`ifdef INT_CTRL_NESTING_EN
    task automatic test_nesting;
        do_reset;
        reg_wr(A_CTRL, 16'h0001);
        reg_wr(A_MASK, 16'h00FF);
        pulse(1 << 2);
        wait_req("nest_req2");
        strobe_ack;
        n_tests++; if (active_id !== 3'd2) begin n_fail++; $display("FAIL nest_id2: got %0d required 2", active_id); end
        pulse(1 << 0);
        wait_req("nest_req0");
        n_tests++; if (int_vector !== vec_of(0)) begin n_fail++; $display("FAIL nest_vector: got %h required %h", int_vector, vec_of(0)); end
        strobe_ack;
        n_tests++; if (active_id !== 3'd0) begin n_fail++; $display("FAIL nest_id0: got %0d required 0", active_id); end
        strobe_done;
        n_tests++; if (active !== 1'b1 || active_id !== 3'd2) begin n_fail++; $display("FAIL nest_pop: got %b/%0d required 1/2", active, active_id); end
        strobe_done;
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL nest_empty: active got %b required 0", active); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_priority;
        test_gie_off;
        test_withdraw;
        test_regs;
        test_reset_service;
`ifdef INT_CTRL_NESTING_EN
        test_nesting;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
